// File: rtl/cdb_pkg.sv
// Shared types and helpers for the Common Data Bus arbiter: field widths, the
// queued result entry, and the round-robin pick function.
package cdb_pkg;

    localparam int ROBEN_W = 5;
    localparam int DATA_W  = 32;
    localparam logic [ROBEN_W-1:0] ROBEN_NONE = '0;

    // Upper bound on sources that rr_pick can arbitrate over.
    localparam int RR_MAX = 16;
    localparam int RR_W   = $clog2(RR_MAX);

    typedef struct packed {
        logic [ROBEN_W-1:0] roben;
        logic [DATA_W-1:0]  data;
        logic               branch_decision;
    } cdb_entry_t;

    // One-hot grant of the first set bit of req scanning upward from ptr+1, modulo n.
    function automatic logic [RR_MAX-1:0] rr_pick(input logic [RR_MAX-1:0] req,
                                                  input int unsigned       ptr,
                                                  input int unsigned       n);
        logic [RR_MAX-1:0] grant;
        int unsigned       idx;
        grant = '0;
        for (int unsigned i = 1; i <= RR_MAX; i++) begin
            idx = (ptr + i) % n;
            if (i <= n && grant == '0 && req[idx[RR_W-1:0]]) begin
                grant[idx[RR_W-1:0]] = 1'b1;
            end
        end
        return grant;
    endfunction

endpackage

// File: rtl/cdb_src_fifo.sv
// Per-source result queue: QDEPTH-entry circular buffer with a combinational head,
// flush taking priority over push and pop.
module cdb_src_fifo
    import cdb_pkg::*;
#(
    parameter int QDEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         push,
    input  logic                         pop,
    input  cdb_entry_t                   din,
    output cdb_entry_t                   head,
    output logic [$clog2(QDEPTH+1)-1:0]  count,
    output logic                         not_full
);

    localparam int AW = $clog2(QDEPTH);
    localparam int CW = $clog2(QDEPTH+1);

    cdb_entry_t      mem [QDEPTH];
    logic [AW-1:0]   rd_ptr_reg;
    logic [AW-1:0]   wr_ptr_reg;
    logic [CW-1:0]   count_reg;
    logic            do_push;
    logic            do_pop;

    assign not_full = (count_reg < CW'(QDEPTH));
    assign do_push  = push && not_full && !flush;
    assign do_pop   = pop && (count_reg != '0) && !flush;
    assign head     = mem[rd_ptr_reg];
    assign count    = count_reg;

    // Storage carries no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
            if (do_push && !do_pop)      count_reg <= count_reg + CW'(1);
            else if (do_pop && !do_push) count_reg <= count_reg - CW'(1);
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB producer: queues functional-unit results and broadcasts one per cycle.
// Define CDB_BRANCH_PRIORITY_EN to give source 0 fixed priority over round-robin.
module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter int N_SRC  = 4,
    parameter int QDEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_SRC-1:0]           src_valid,
    output logic [N_SRC-1:0]           src_ready,
    input  logic [N_SRC*ROBEN_W-1:0]   src_roben,
    input  logic [N_SRC*DATA_W-1:0]    src_data,
    input  logic [N_SRC-1:0]           src_branch_decision,
    input  logic                       flush,
    output logic [ROBEN_W-1:0]         CDB_ROBEN,
    output logic [DATA_W-1:0]          CDB_ROBEN_Write_Data,
    output logic                       CDB_Branch_Decision,
    output logic [N_SRC-1:0]           cdb_grant
);

    localparam int PTR_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam int CW    = $clog2(QDEPTH+1);

    cdb_entry_t         src_entry [N_SRC];
    cdb_entry_t         head      [N_SRC];
    logic [CW-1:0]      count_w   [N_SRC];
    logic [N_SRC-1:0]   nonempty;
    logic [N_SRC-1:0]   grant;
    logic               prio_grant;
    logic [PTR_W-1:0]   win_idx;
    cdb_entry_t         win_entry;

    logic [PTR_W-1:0]   ptr_reg;
    logic [ROBEN_W-1:0] cdb_roben_reg;
    logic [DATA_W-1:0]  cdb_data_reg;
    logic               cdb_branch_reg;
    logic [N_SRC-1:0]   cdb_grant_reg;

    genvar gi;
    generate
        for (gi = 0; gi < N_SRC; gi++) begin : g_src
            assign src_entry[gi] = {src_roben[gi*ROBEN_W +: ROBEN_W],
                                    src_data[gi*DATA_W +: DATA_W],
                                    src_branch_decision[gi]};
            assign nonempty[gi]  = (count_w[gi] != '0);

            // Reserved-tag results complete the handshake but never occupy a slot.
            cdb_src_fifo #(.QDEPTH(QDEPTH)) u_fifo (
                .clk      (clk),
                .rst      (rst),
                .flush    (flush),
                .push     (src_valid[gi] && (src_roben[gi*ROBEN_W +: ROBEN_W] != ROBEN_NONE)),
                .pop      (grant[gi]),
                .din      (src_entry[gi]),
                .head     (head[gi]),
                .count    (count_w[gi]),
                .not_full (src_ready[gi])
            );
        end
    endgenerate

    always_comb begin
        grant      = '0;
        prio_grant = 1'b0;
`ifdef CDB_BRANCH_PRIORITY_EN
        if (nonempty[0]) begin
            grant[0]   = 1'b1;
            prio_grant = 1'b1;
        end else begin
            grant = N_SRC'(rr_pick(RR_MAX'(nonempty & ~N_SRC'(1)), 32'(ptr_reg), N_SRC));
        end
`else
        grant = N_SRC'(rr_pick(RR_MAX'(nonempty), 32'(ptr_reg), N_SRC));
`endif
    end

    always_comb begin
        win_idx   = '0;
        win_entry = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (grant[i]) begin
                win_idx   = PTR_W'(i);
                win_entry = head[i];
            end
        end
    end

    // With no winner win_entry is all zero, so the idle values load naturally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_reg        <= PTR_W'(N_SRC-1);
            cdb_roben_reg  <= ROBEN_NONE;
            cdb_data_reg   <= '0;
            cdb_branch_reg <= 1'b0;
            cdb_grant_reg  <= '0;
        end else if (flush) begin
            cdb_roben_reg  <= ROBEN_NONE;
            cdb_data_reg   <= '0;
            cdb_branch_reg <= 1'b0;
            cdb_grant_reg  <= '0;
        end else begin
            cdb_roben_reg  <= win_entry.roben;
            cdb_data_reg   <= win_entry.data;
            cdb_branch_reg <= win_entry.branch_decision;
            cdb_grant_reg  <= grant;
            if ((|grant) && !prio_grant) begin
                ptr_reg <= win_idx;
            end
        end
    end

    assign CDB_ROBEN            = cdb_roben_reg;
    assign CDB_ROBEN_Write_Data = cdb_data_reg;
    assign CDB_Branch_Decision  = cdb_branch_reg;
    assign cdb_grant            = cdb_grant_reg;

endmodule
